// File: rtl/sensor_chain_scanner.sv
// Scans a 74HC165-style PISO sensor chain, debounces whole scan words and reports changes to the CPU.
// Latency: trigger to data_valid is (NUM_BITS+1)*2*CLK_DIV+1 clk cycles (load + NUM_BITS slots + DONE).
// Backpressure: none; start/periodic triggers arriving while busy are dropped, outputs are pulses and levels.
module sensor_chain_scanner #(
    parameter int NUM_BITS    = 32,
    parameter int CLK_DIV     = 4,
    parameter int SCAN_PERIOD = 8000,
    parameter int DEBOUNCE    = 2,
    parameter int INVERT      = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                start,
    input  logic                in_val,
    output logic                sr_clk,
    output logic                pl_n,
    output logic [NUM_BITS-1:0] sensor_data,
    output logic [NUM_BITS-1:0] changed,
    output logic                data_valid,
    output logic                data_changed,
    output logic                busy
);

    // Cycles per LOAD phase / per SHIFT slot (one full sr_clk period).
    localparam int PHASES = 2 * CLK_DIV;
    localparam int PW     = (PHASES > 1) ? $clog2(PHASES) : 1;
    localparam int IW     = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int PCW    = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam int SW     = $clog2(DEBOUNCE + 1);

    localparam logic [PW-1:0]  PHASE_LAST     = PW'(PHASES - 1);
    localparam logic [PW-1:0]  PHASE_LOW_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0]  PHASE_HIGH     = PW'(CLK_DIV);
    localparam logic [IW-1:0]  LAST_BIT       = IW'(NUM_BITS - 1);
    localparam logic [PCW-1:0] PERIOD_LAST    = PCW'(SCAN_PERIOD - 1);
    localparam logic [SW-1:0]  DEB_MAX        = SW'(DEBOUNCE);
    localparam logic           INV_BIT        = (INVERT != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [PW-1:0]       phase_q;
    logic [PW-1:0]       phase_d;
    logic [IW-1:0]       bit_q;
    logic [IW-1:0]       bit_d;
    logic [PCW-1:0]      period_q;
    logic [PCW-1:0]      period_d;
    logic [NUM_BITS-1:0] raw_q;
    logic [NUM_BITS-1:0] raw_d;
    logic [NUM_BITS-1:0] cand_q;
    logic [NUM_BITS-1:0] cand_next;
    logic [SW-1:0]       stable_q;
    logic [SW-1:0]       stable_next;

    logic trigger;
    logic scan_start;
    logic slot_end;
    logic sample_now;
    logic done_entry;
    logic do_update;

    logic sr_clk_d;
    logic pl_n_d;
    logic data_valid_d;
    logic data_changed_d;

    // A start pulse and a periodic tick in the same cycle collapse into one scan.
    assign trigger    = start || (enable && (period_q == PERIOD_LAST));
    assign scan_start = (state_q == IDLE) && trigger;
    assign slot_end   = (phase_q == PHASE_LAST);
    // Sample on the last low-half cycle so the bit is captured just before the chain shifts.
    assign sample_now = (state_q == SHIFT) && (phase_q == PHASE_LOW_LAST);
    // Debounce results are registered on the edge into DONE so they are visible during DONE.
    assign done_entry = (state_q == SHIFT) && slot_end && (bit_q == LAST_BIT);
    assign busy       = (state_q != IDLE);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> LOAD -> SHIFT (NUM_BITS slots) -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (trigger) state_d = LOAD;
            LOAD:    if (slot_end) state_d = SHIFT;
            SHIFT:   if (slot_end && (bit_q == LAST_BIT)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Phase, bit-index and period counters plus the raw shift capture.
    always_comb begin
        phase_d = '0;
        if ((state_q == LOAD) || (state_q == SHIFT)) begin
            phase_d = slot_end ? '0 : (phase_q + PW'(1));
        end

        bit_d = bit_q;
        if (state_q != SHIFT) begin
            bit_d = '0;
        end else if (slot_end) begin
            bit_d = bit_q + IW'(1);
        end

        period_d = period_q;
        if (scan_start) begin
            period_d = '0;
        end else if (enable) begin
            period_d = (period_q == PERIOD_LAST) ? '0 : (period_q + PCW'(1));
        end

        raw_d = raw_q;
        if (sample_now) begin
            for (int i = 0; i < NUM_BITS; i++) begin
                if (bit_q == IW'(i)) begin
                    raw_d[i] = in_val ^ INV_BIT;
                end
            end
        end
    end

    // Debounce evaluation of the completed raw word against the current candidate.
    always_comb begin
        cand_next   = cand_q;
        stable_next = stable_q;
        if (raw_q != cand_q) begin
            cand_next   = raw_q;
            stable_next = SW'(1);
        end else if (stable_q != DEB_MAX) begin
            stable_next = stable_q + SW'(1);
        end
        do_update = (stable_next == DEB_MAX) && (cand_next != sensor_data);
    end

    // Output logic: next values of the registered chain strobes and CPU pulses.
    always_comb begin
        sr_clk_d       = (state_d == SHIFT) && (phase_d >= PHASE_HIGH);
        pl_n_d         = (state_d != LOAD);
        data_valid_d   = done_entry;
        data_changed_d = done_entry && do_update;
    end

    // Datapath registers and registered outputs; everything clears asynchronously on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q      <= '0;
            bit_q        <= '0;
            period_q     <= '0;
            raw_q        <= '0;
            cand_q       <= '0;
            stable_q     <= '0;
            sensor_data  <= '0;
            changed      <= '0;
            sr_clk       <= 1'b0;
            pl_n         <= 1'b1;
            data_valid   <= 1'b0;
            data_changed <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            bit_q        <= bit_d;
            period_q     <= period_d;
            raw_q        <= raw_d;
            sr_clk       <= sr_clk_d;
            pl_n         <= pl_n_d;
            data_valid   <= data_valid_d;
            data_changed <= data_changed_d;
            if (done_entry) begin
                cand_q   <= cand_next;
                stable_q <= stable_next;
                if (do_update) begin
                    sensor_data <= cand_next;
                    changed     <= cand_next ^ sensor_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_sensor_chain_scanner.sv
// Bench for sensor_chain_scanner: three instances (DEBOUNCE=1, DEBOUNCE=2, INVERT=1) fed by 74HC165 chain models.
// Latency: expects data_valid 37 cycles after the start cycle for NUM_BITS=8, CLK_DIV=2.
// Backpressure: none; stimulus is start/enable pulses, results are checked against a word-history model.
module tb_sensor_chain_scanner;

    localparam int NB = 8;
    localparam int CD = 2;
    localparam int SP = 100;

    logic clk = 1'b0;
    logic reset_n;
    logic enable;
    logic start;

    logic       in_val  [3];
    logic       sr_clk  [3];
    logic       pl_n    [3];
    logic       dv      [3];
    logic       dc      [3];
    logic       busy    [3];
    logic [7:0] sd      [3];
    logic [7:0] chg     [3];
    logic [7:0] chain_word [3];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: per-instance history of scanned (post-invert) words.
    logic [7:0] log_raw [3][256];
    int         nscan   [3];
    logic [7:0] m_sd    [3];
    logic [7:0] m_chg   [3];

    initial forever #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [7:0] sh;

        // 74HC165 behaviour: async parallel load while pl_n low, shift toward Q7 on sr_clk rise.
        always @(posedge sr_clk[g] or negedge pl_n[g]) begin
            if (!pl_n[g]) sh <= chain_word[g];
            else          sh <= {1'b0, sh[7:1]};
        end
        assign in_val[g] = sh[0];

        sensor_chain_scanner #(
            .NUM_BITS    (NB),
            .CLK_DIV     (CD),
            .SCAN_PERIOD (SP),
            .DEBOUNCE    ((g == 1) ? 2 : 1),
            .INVERT      ((g == 2) ? 1 : 0)
        ) u_dut (
            .clk          (clk),
            .reset_n      (reset_n),
            .enable       (enable),
            .start        (start),
            .in_val       (in_val[g]),
            .sr_clk       (sr_clk[g]),
            .pl_n         (pl_n[g]),
            .sensor_data  (sd[g]),
            .changed      (chg[g]),
            .data_valid   (dv[g]),
            .data_changed (dc[g]),
            .busy         (busy[g])
        );
    end

    task automatic model_reset();
        for (int g = 0; g < 3; g++) begin
            nscan[g] = 0;
            m_sd[g]  = 8'h00;
            m_chg[g] = 8'h00;
        end
    endtask

    // The word is accepted once the last DEBOUNCE scans all read the same value and it differs from the output.
    task automatic model_scan(input int g, input logic [7:0] w, output bit exp_dc);
        logic [7:0] r;
        bit         stable;
        int         deb;
        r   = w ^ ((g == 2) ? 8'hFF : 8'h00);
        deb = (g == 1) ? 2 : 1;
        log_raw[g][nscan[g] % 256] = r;
        nscan[g]++;
        stable = (nscan[g] >= deb);
        for (int i = 1; i <= deb; i++) begin
            if ((nscan[g] >= i) && (log_raw[g][(nscan[g] - i) % 256] != r)) stable = 1'b0;
        end
        exp_dc = stable && (r != m_sd[g]);
        if (exp_dc) begin
            m_chg[g] = r ^ m_sd[g];
            m_sd[g]  = r;
        end
    endtask

    // One start-triggered scan on all instances, checked cycle by cycle against the model.
    task automatic run_scan(input bit chk_timing);
        bit   exp_dc [3];
        int   dv_cnt [3];
        int   dc_cnt [3];
        int   dv_at  [3];
        int   pl_first, pl_last, pl_cnt, rises, busy_hi;
        logic prev_sr;
        pl_first = -1; pl_last = -1; pl_cnt = 0; rises = 0; busy_hi = 0; prev_sr = 1'b0;
        for (int g = 0; g < 3; g++) begin
            model_scan(g, chain_word[g], exp_dc[g]);
            dv_cnt[g] = 0; dc_cnt[g] = 0; dv_at[g] = -1;
        end
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int n = 1; n <= 45; n++) begin
            if (n > 1) @(negedge clk);
            if (!pl_n[0]) begin
                if (pl_first < 0) pl_first = n;
                pl_last = n;
                pl_cnt++;
            end
            if (sr_clk[0] && !prev_sr) rises++;
            prev_sr = sr_clk[0];
            if (busy[0]) busy_hi++;
            for (int g = 0; g < 3; g++) begin
                if (dc[g]) dc_cnt[g]++;
                if (dv[g]) begin
                    dv_cnt[g]++;
                    dv_at[g] = n;
                    n_cmp++;
                    if (sd[g] !== m_sd[g]) begin
                        n_bad++;
                        $display("FAIL dut%0d sensor_data: got %h want %h", g, sd[g], m_sd[g]);
                    end
                    n_cmp++;
                    if (chg[g] !== m_chg[g]) begin
                        n_bad++;
                        $display("FAIL dut%0d changed: got %h want %h", g, chg[g], m_chg[g]);
                    end
                end
            end
        end
        for (int g = 0; g < 3; g++) begin
            n_cmp++;
            if (dv_cnt[g] !== 1) begin
                n_bad++;
                $display("FAIL dut%0d data_valid count: got %0d want 1", g, dv_cnt[g]);
            end
            n_cmp++;
            if (dv_at[g] !== 37) begin
                n_bad++;
                $display("FAIL dut%0d data_valid cycle: got %0d want 37", g, dv_at[g]);
            end
            n_cmp++;
            if (dc_cnt[g] !== int'(exp_dc[g])) begin
                n_bad++;
                $display("FAIL dut%0d data_changed count: got %0d want %0d", g, dc_cnt[g], exp_dc[g]);
            end
        end
        if (chk_timing) begin
            n_cmp++;
            if ((pl_first !== 1) || (pl_last !== 4) || (pl_cnt !== 4)) begin
                n_bad++;
                $display("FAIL pl_n window: got first %0d last %0d count %0d want 1 4 4", pl_first, pl_last, pl_cnt);
            end
            n_cmp++;
            if (rises !== 8) begin
                n_bad++;
                $display("FAIL sr_clk rises: got %0d want 8", rises);
            end
            n_cmp++;
            if (busy_hi !== 37) begin
                n_bad++;
                $display("FAIL busy cycles: got %0d want 37", busy_hi);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        for (int g = 0; g < 3; g++) begin
            n_cmp++;
            if ({sr_clk[g], pl_n[g], dv[g], dc[g], busy[g], sd[g], chg[g]} !== {5'b01000, 16'h0000}) begin
                n_bad++;
                $display("FAIL %s dut%0d: got sr_clk %b pl_n %b dv %b dc %b busy %b sd %h chg %h want 0 1 0 0 0 00 00",
                         tag, g, sr_clk[g], pl_n[g], dv[g], dc[g], busy[g], sd[g], chg[g]);
            end
        end
    endtask

    task automatic check_word(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; start = 1'b0;
        chain_word = '{8'h00, 8'h00, 8'h00};
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_directed();
        chain_word = '{8'hA5, 8'h0F, 8'hFF};
        run_scan(1'b1);
        check_word("scan1 sd0", sd[0], 8'hA5);
        check_word("scan1 chg0", chg[0], 8'hA5);
        check_word("scan1 sd1 held", sd[1], 8'h00);
        chain_word = '{8'hA4, 8'hF0, 8'hFF};
        run_scan(1'b1);
        check_word("scan2 sd0", sd[0], 8'hA4);
        check_word("scan2 chg0", chg[0], 8'h01);
        check_word("scan2 sd1 held", sd[1], 8'h00);
        run_scan(1'b0);
        check_word("scan3 chg0 held", chg[0], 8'h01);
        check_word("scan3 sd1", sd[1], 8'hF0);
        check_word("scan3 sd2 inverted", sd[2], 8'h00);
    endtask

    task automatic test_invert();
        for (int i = 0; i < 3; i++) begin
            chain_word[0] = 8'($urandom);
            chain_word[1] = 8'($urandom);
            chain_word[2] = 8'hFF;
            run_scan(1'b0);
        end
        check_word("invert all-ones sd2", sd[2], 8'h00);
        chain_word[2] = 8'h3C;
        run_scan(1'b0);
        check_word("invert 3C sd2", sd[2], 8'hC3);
    endtask

    task automatic test_back_to_back();
        logic [7:0] pool [4];
        pool = '{8'h00, 8'hFF, 8'hA5, 8'h5A};
        for (int i = 0; i < 24; i++) begin
            for (int g = 0; g < 3; g++) begin
                if ($urandom_range(0, 3) == 0) chain_word[g] = 8'($urandom);
                else                           chain_word[g] = pool[$urandom_range(0, 3)];
            end
            run_scan(1'b0);
        end
    endtask

    task automatic test_periodic();
        int   f0, f1, f2, nf, dv_n, last_dv;
        logic prev_pl;
        f0 = -1; f1 = -1; f2 = -1; nf = 0; dv_n = 0; last_dv = -1; prev_pl = 1'b1;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        chain_word = '{8'h3C, 8'h3C, 8'h3C};
        enable = 1'b1;
        for (int n = 0; n < 700; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (prev_pl && !pl_n[0]) begin
                if (nf == 0)      f0 = n;
                else if (nf == 1) f1 = n;
                else if (nf == 2) f2 = n;
                nf++;
            end
            prev_pl = pl_n[0];
            if (dv[0]) begin
                dv_n++;
                last_dv = n;
            end
            if ((nf == 2) && (n == f1 + 10)) start = 1'b1;
            if ((nf == 3) && (n == f2 + 10)) enable = 1'b0;
        end
        start = 1'b0;
        n_cmp++;
        if (nf !== 3) begin
            n_bad++;
            $display("FAIL periodic scan count: got %0d want 3", nf);
        end
        n_cmp++;
        if ((f1 - f0) !== SP) begin
            n_bad++;
            $display("FAIL periodic gap1: got %0d want %0d", f1 - f0, SP);
        end
        n_cmp++;
        if ((f2 - f1) !== SP) begin
            n_bad++;
            $display("FAIL periodic gap2 (start while busy): got %0d want %0d", f2 - f1, SP);
        end
        n_cmp++;
        if ((dv_n !== 3) || (last_dv !== f2 + 36)) begin
            n_bad++;
            $display("FAIL periodic completion: got %0d valids last at %0d want 3 at %0d", dv_n, last_dv, f2 + 36);
        end
        check_word("periodic sd0", sd[0], 8'h3C);
    endtask

    task automatic test_reset_midscan();
        chain_word = '{8'h81, 8'h81, 8'h81};
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (14) @(negedge clk);
        n_cmp++;
        if (busy[0] !== 1'b1 || pl_n[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL midscan precondition: got busy %b pl_n %b want 1 1", busy[0], pl_n[0]);
        end
        reset_n = 1'b0;
        #1;
        check_reset_values("midscan reset");
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        chain_word = '{8'h6E, 8'h6E, 8'h6E};
        run_scan(1'b1);
        check_word("post-reset sd0", sd[0], 8'h6E);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_invert();
        test_back_to_back();
        test_periodic();
        test_reset_midscan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
